i2c_mem_arb: RTL and testbench



---
 rtl/i2c_mem_arb.sv | 147 ++++++++++++++
 tb/tb_i2c_mem_arb.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_mem_arb.sv
// Round-robin arbiter that shares one I2C memory master among NREQ requesters,
// with a per-transaction timeout and a one-cycle registered response.
module i2c_mem_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned TO_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ*8-1:0] req_din,
    output logic [NREQ-1:0]   gnt,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_start,
    output logic              m_wr,
    output logic [6:0]        m_addr,
    output logic [7:0]        m_din,
    input  logic [7:0]        m_rdata,
    input  logic              m_done
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TO_W-1:0] TO_LIM = {TO_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [TO_W-1:0] cnt, cnt_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            rsp_valid_nxt, rsp_err_nxt, busy_nxt;
    logic [7:0]      rsp_data_nxt;
    logic            m_start_nxt, m_wr_nxt;
    logic [6:0]      m_addr_nxt;
    logic [7:0]      m_din_nxt;
    logic            sel_any;
    logic [IW-1:0]   sel_idx;

    // First pending requester at or after ptr; descending scan so the nearest one wins.
    always_comb begin : p_sel
        int j;
        sel_any = 1'b0;
        sel_idx = '0;
        j       = 0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % int'(NREQ);
            if (req[IW'(j)]) begin
                sel_any = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    // Counter holds the number of cycles elapsed since the m_start cycle.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        idx_nxt       = idx;
        cnt_nxt       = cnt;
        gnt_nxt       = gnt;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        m_start_nxt   = 1'b0;
        m_wr_nxt      = m_wr;
        m_addr_nxt    = m_addr;
        m_din_nxt     = m_din;
        case (state)
            IDLE: begin
                if (sel_any) begin
                    idx_nxt     = sel_idx;
                    gnt_nxt     = NREQ'(1) << sel_idx;
                    m_wr_nxt    = req_wr[sel_idx];
                    m_addr_nxt  = req_addr[int'(sel_idx)*7 +: 7];
                    m_din_nxt   = req_din[int'(sel_idx)*8 +: 8];
                    m_start_nxt = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt   = cnt + TO_W'(1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    rsp_data_nxt  = m_wr ? 8'h00 : m_rdata;
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else begin
                    cnt_nxt = cnt + TO_W'(1);
                    if (cnt_nxt == TO_LIM) begin
                        rsp_data_nxt  = 8'h00;
                        rsp_err_nxt   = 1'b1;
                        rsp_valid_nxt = 1'b1;
                        state_nxt     = RESP;
                    end
                end
            end
            RESP: begin
                gnt_nxt   = '0;
                ptr_nxt   = (int'(idx) == int'(NREQ) - 1) ? '0 : idx + IW'(1);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            m_start   <= 1'b0;
            m_wr      <= 1'b0;
            m_addr    <= 7'h00;
            m_din     <= 8'h00;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            gnt       <= gnt_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            busy      <= busy_nxt;
            m_start   <= m_start_nxt;
            m_wr      <= m_wr_nxt;
            m_addr    <= m_addr_nxt;
            m_din     <= m_din_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_mem_arb.sv
// Scoreboard bench for i2c_mem_arb: a default instance for arbitration/data
// checks and a TO_W=4 instance for the timeout path.
module tb_i2c_mem_arb;
    localparam int unsigned NREQ = 4;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            wr;
        logic [6:0]      addr;
        logic [7:0]      din;
    } st_exp_t;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic [7:0]      data;
        logic            err;
        int              lat;
    } rsp_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]   req, req_wr, gnt;
    logic [NREQ*7-1:0] req_addr;
    logic [NREQ*8-1:0] req_din;
    logic              rsp_valid, rsp_err, busy, m_start, m_wr, m_done;
    logic [7:0]        rsp_data, m_din, m_rdata;
    logic [6:0]        m_addr;
    logic              m_done_mem = 1'b0;
    logic              m_done_stray = 1'b0;
    assign m_done = m_done_mem | m_done_stray;

    logic [NREQ-1:0]   t_req, t_gnt;
    logic              t_rsp_valid, t_rsp_err, t_busy, t_m_start, t_m_wr;
    logic [7:0]        t_rsp_data, t_m_din;
    logic [6:0]        t_m_addr;
    logic              t_m_done = 1'b0;

    i2c_mem_arb #(.NREQ(NREQ), .TO_W(10)) u_main (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy), .m_start(m_start), .m_wr(m_wr),
        .m_addr(m_addr), .m_din(m_din), .m_rdata(m_rdata), .m_done(m_done)
    );

    i2c_mem_arb #(.NREQ(NREQ), .TO_W(4)) u_to (
        .clk(clk), .rst(rst), .req(t_req), .req_wr(req_wr), .req_addr(req_addr),
        .req_din(req_din), .gnt(t_gnt), .rsp_valid(t_rsp_valid), .rsp_data(t_rsp_data),
        .rsp_err(t_rsp_err), .busy(t_busy), .m_start(t_m_start), .m_wr(t_m_wr),
        .m_addr(t_m_addr), .m_din(t_m_din), .m_rdata(m_rdata), .m_done(t_m_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_dly = 0;
    int t_mem_dly = 0;
    st_exp_t  start_q[$];
    rsp_exp_t rsp_q[$];
    rsp_exp_t t_rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory models: pulse m_done mem_dly cycles after the m_start cycle (0 = never).
    always begin
        @(negedge clk);
        if (m_start && !rst && mem_dly > 0) begin
            repeat (mem_dly) @(posedge clk);
            #1 m_done_mem = 1'b1;
            @(posedge clk);
            #1 m_done_mem = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (t_m_start && !rst && t_mem_dly > 0) begin
            repeat (t_mem_dly) @(posedge clk);
            #1 t_m_done = 1'b1;
            @(posedge clk);
            #1 t_m_done = 1'b0;
        end
    end

    // Monitor for the default instance.
    int      t_start = 0;
    int      last_start = -100;
    logic    cur_valid = 1'b0;
    st_exp_t cur;
    always @(negedge clk) begin
        st_exp_t  se;
        rsp_exp_t re;
        if (rst) begin
            cur_valid  = 1'b0;
            last_start = -100;
        end else begin
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (m_start) begin
                if (start_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_start actual gnt=%b required no start", gnt);
                end else begin
                    se = start_q.pop_front();
                    chk("start_gnt", 32'(gnt), 32'(se.gnt));
                    chk("start_wr", 32'(m_wr), 32'(se.wr));
                    chk("start_addr", 32'(m_addr), 32'(se.addr));
                    chk("start_din", 32'(m_din), 32'(se.din));
                    chk("start_gap", 32'((cyc - last_start) >= 3), 32'd1);
                    last_start = cyc;
                    t_start    = cyc;
                    cur        = se;
                    cur_valid  = 1'b1;
                end
            end else if (busy && cur_valid) begin
                chk("hold_gnt", 32'(gnt), 32'(cur.gnt));
                chk("hold_addr", 32'(m_addr), 32'(cur.addr));
                chk("hold_din", 32'(m_din), 32'(cur.din));
                chk("hold_wr", 32'(m_wr), 32'(cur.wr));
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual data=%0h required no response", rsp_data);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_gnt", 32'(gnt), 32'(re.gnt));
                    chk("rsp_data", 32'(rsp_data), 32'(re.data));
                    chk("rsp_err", 32'(rsp_err), 32'(re.err));
                    chk("rsp_lat", 32'(cyc - t_start), 32'(re.lat));
                end
                cur_valid = 1'b0;
            end
        end
    end

    // Monitor for the timeout instance.
    int tt_start = 0;
    always @(negedge clk) begin
        rsp_exp_t re;
        if (!rst) begin
            if (t_m_start) tt_start = cyc;
            if (t_rsp_valid) begin
                if (t_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL t_unexpected_rsp actual data=%0h required no response", t_rsp_data);
                end else begin
                    re = t_rsp_q.pop_front();
                    chk("t_rsp_gnt", 32'(t_gnt), 32'(re.gnt));
                    chk("t_rsp_data", 32'(t_rsp_data), 32'(re.data));
                    chk("t_rsp_err", 32'(t_rsp_err), 32'(re.err));
                    chk("t_rsp_lat", 32'(cyc - tt_start), 32'(re.lat));
                end
            end
        end
    end

    // mode 1: scramble the requester's inputs after launch; mode 2: drop req after launch.
    task automatic txn(input int k, input logic wr, input logic [6:0] a, input logic [7:0] d,
                       input logic [7:0] rdat, input int lat, input int mode);
        st_exp_t  se;
        rsp_exp_t re;
        logic     got;
        req_wr[k]          = wr;
        req_addr[7*k +: 7] = a;
        req_din[8*k +: 8]  = d;
        m_rdata            = rdat;
        se.gnt  = NREQ'(1) << k;
        se.wr   = wr;
        se.addr = a;
        se.din  = d;
        start_q.push_back(se);
        re.gnt  = se.gnt;
        re.data = wr ? 8'h00 : rdat;
        re.err  = 1'b0;
        re.lat  = lat;
        rsp_q.push_back(re);
        req[k] = 1'b1;
        got    = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (m_start && mode == 1) begin
                req_addr[7*k +: 7] = ~a;
                req_din[8*k +: 8]  = ~d;
                req_wr[k]          = ~wr;
            end
            if (m_start && mode == 2) req[k] = 1'b0;
            if (rsp_valid && gnt[k]) got = 1'b1;
        end
        req[k] = 1'b0;
        chk("rsp_arrived", 32'(got), 32'd1);
    endtask

    task automatic t_wait(input int k);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (t_rsp_valid && t_gnt[k]) got = 1'b1;
        end
        t_req[k] = 1'b0;
        chk("t_rsp_arrived", 32'(got), 32'd1);
    endtask

    initial begin
        st_exp_t  se;
        rsp_exp_t re;
        int       n;
        logic     seen;
        rst      = 1'b1;
        req      = '0;
        t_req    = '0;
        req_wr   = 4'b0101;
        req_addr = '0;
        req_din  = '0;
        m_rdata  = 8'h3C;
        mem_dly  = 2;
        for (int k = 0; k < 4; k++) begin
            req_addr[7*k +: 7] = 7'(16 + k);
            req_din[8*k +: 8]  = 8'(32 + k);
        end
        // Contention: expected grant order 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            se.gnt  = NREQ'(1) << (i % 4);
            se.wr   = req_wr[i % 4];
            se.addr = 7'(16 + (i % 4));
            se.din  = 8'(32 + (i % 4));
            start_q.push_back(se);
            re.gnt  = se.gnt;
            re.data = se.wr ? 8'h00 : 8'h3C;
            re.err  = 1'b0;
            re.lat  = 3;
            rsp_q.push_back(re);
        end
        req = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_t_gnt", 32'(t_gnt), 32'd0);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 200 && n < 5; c++) begin
            @(negedge clk);
            if (rsp_valid) n++;
        end
        req = '0;
        chk("contention_rsps", 32'(n), 32'd5);

        // Single write with input disturbance; memory answers 20 cycles after m_start.
        mem_dly = 20;
        txn(0, 1'b1, 7'h12, 8'hA5, 8'hEE, 21, 1);
        // Single read on requester 2, which drops req mid-transaction.
        mem_dly = 3;
        txn(2, 1'b0, 7'h12, 8'h00, 8'hA5, 4, 2);

        // Stray m_done while idle must not produce a response.
        @(negedge clk);
        m_done_stray = 1'b1;
        @(negedge clk);
        m_done_stray = 1'b0;
        repeat (2) @(negedge clk);
        chk("stray_busy", 32'(busy), 32'd0);

        // Reset in WAIT abandons the transaction and returns ptr to 0.
        mem_dly = 0;
        req_wr[0] = 1'b0;
        req_addr[6:0] = 7'h33;
        req_din[7:0] = 8'h00;
        se.gnt = 4'b0001; se.wr = 1'b0; se.addr = 7'h33; se.din = 8'h00;
        start_q.push_back(se);
        req[0] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (m_start) seen = 1'b1;
        end
        chk("rst_test_start", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_m_start", 32'(m_start), 32'd0);
        chk("mid_rst_m_wr", 32'(m_wr), 32'd0);
        chk("mid_rst_m_addr", 32'(m_addr), 32'd0);
        chk("mid_rst_m_din", 32'(m_din), 32'd0);
        req[0] = 1'b0;
        rst = 1'b0;

        // With ptr back at 0, requester 0 wins over 3, then 3 is served next.
        mem_dly = 1;
        req_wr[3] = 1'b0;
        req_addr[27:21] = 7'h66;
        req_din[31:24] = 8'h00;
        req[3] = 1'b1;
        txn(0, 1'b1, 7'h44, 8'h55, 8'h00, 2, 0);
        txn(3, 1'b0, 7'h66, 8'h00, 8'h99, 2, 0);

        // Timeout instance: no m_done, then a normal read.
        t_mem_dly = 0;
        req_wr[1] = 1'b0;
        req_addr[13:7] = 7'h21;
        re.gnt = 4'b0010; re.data = 8'h00; re.err = 1'b1; re.lat = 15;
        t_rsp_q.push_back(re);
        t_req[1] = 1'b1;
        t_wait(1);
        t_mem_dly = 2;
        m_rdata = 8'h77;
        req_wr[0] = 1'b0;
        re.gnt = 4'b0001; re.data = 8'h77; re.err = 1'b0; re.lat = 3;
        t_rsp_q.push_back(re);
        t_req[0] = 1'b1;
        t_wait(0);

        repeat (3) @(negedge clk);
        chk("start_q_empty", 32'(start_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        chk("t_rsp_q_empty", 32'(t_rsp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
